// File: rtl/fetch_stage.sv
// LC-3b fetch stage: owns the PC and the DE pipeline latch, honours decode/MEM
// stalls and MEM-stage redirects, and keeps saturating fetch/bubble counters.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [15:0]      icache_addr,
    input  logic             icache_r,
    input  logic [15:0]      icache_data,
    input  logic             dep_stall,
    input  logic             mem_stall,
    input  logic             v_de_br_stall,
    input  logic             v_agex_br_stall,
    input  logic             v_mem_br_stall,
    input  logic [1:0]       mem_pcmux,
    input  logic [15:0]      target_pc,
    input  logic [15:0]      trap_pc,
    output logic [15:0]      de_npc,
    output logic [15:0]      de_ir,
    output logic             de_v,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] bubble_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [15:0]      pc_q, pc_d;
    logic [15:0]      de_npc_q, de_npc_d;
    logic [15:0]      de_ir_q, de_ir_d;
    logic             de_v_q, de_v_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic        ld_de_s, br_block_s, fetch_ok_s, redirect_s;
    logic [15:0] pc_plus2_s;

    always_comb begin
        ld_de_s    = ~dep_stall & ~mem_stall;
        br_block_s = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;
        fetch_ok_s = icache_r & ~br_block_s;
        redirect_s = v_mem_br_stall & ~mem_stall;
        pc_plus2_s = pc_q + 16'h0002;
    end

    // Redirect outranks sequential fetch and never fetches in the same cycle.
    always_comb begin
        pc_d = pc_q;
        if (redirect_s) begin
            case (mem_pcmux)
                2'd1:    pc_d = target_pc;
                2'd2:    pc_d = trap_pc;
                default: pc_d = pc_q;
            endcase
        end else if (fetch_ok_s && ld_de_s) begin
            pc_d = pc_plus2_s;
        end else begin
            pc_d = pc_q;
        end
    end

    // DE fields load together whenever decode accepts, even for a bubble.
    always_comb begin
        de_v_d       = de_v_q;
        de_ir_d      = de_ir_q;
        de_npc_d     = de_npc_q;
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (ld_de_s) begin
            de_v_d   = fetch_ok_s;
            de_ir_d  = icache_data;
            de_npc_d = pc_plus2_s;
            if (fetch_ok_s) begin
                if (fetch_cnt_q != CNT_MAX) begin
                    fetch_cnt_d = fetch_cnt_q + CNT_ONE;
                end else begin
                    fetch_cnt_d = fetch_cnt_q;
                end
            end else begin
                if (bubble_cnt_q != CNT_MAX) begin
                    bubble_cnt_d = bubble_cnt_q + CNT_ONE;
                end else begin
                    bubble_cnt_d = bubble_cnt_q;
                end
            end
        end else begin
            de_v_d = de_v_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            de_npc_q     <= 16'h0000;
            de_ir_q      <= 16'h0000;
            de_v_q       <= 1'b0;
            fetch_cnt_q  <= {CNT_W{1'b0}};
            bubble_cnt_q <= {CNT_W{1'b0}};
        end else begin
            pc_q         <= pc_d;
            de_npc_q     <= de_npc_d;
            de_ir_q      <= de_ir_d;
            de_v_q       <= de_v_d;
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign icache_addr  = pc_q;
    assign de_npc       = de_npc_q;
    assign de_ir        = de_ir_q;
    assign de_v         = de_v_q;
    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a driver applies directed then random
// stimulus and queues model predictions; a monitor compares each cycle.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, icache_r, dep_stall, mem_stall;
    logic        v_de_br_stall, v_agex_br_stall, v_mem_br_stall;
    logic [1:0]  mem_pcmux;
    logic [15:0] icache_data, target_pc, trap_pc;

    logic [15:0] icache_addr, de_npc, de_ir, fetch_count, bubble_count;
    logic        de_v;
    logic [15:0] icache_addr4, de_npc4, de_ir4;
    logic        de_v4;
    logic [3:0]  fetch_count4, bubble_count4;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(16'h3000), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .icache_addr(icache_addr), .icache_r(icache_r),
        .icache_data(icache_data), .dep_stall(dep_stall), .mem_stall(mem_stall),
        .v_de_br_stall(v_de_br_stall), .v_agex_br_stall(v_agex_br_stall),
        .v_mem_br_stall(v_mem_br_stall), .mem_pcmux(mem_pcmux), .target_pc(target_pc),
        .trap_pc(trap_pc), .de_npc(de_npc), .de_ir(de_ir), .de_v(de_v),
        .fetch_count(fetch_count), .bubble_count(bubble_count));

    fetch_stage #(.RESET_PC(16'h3000), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .icache_addr(icache_addr4), .icache_r(icache_r),
        .icache_data(icache_data), .dep_stall(dep_stall), .mem_stall(mem_stall),
        .v_de_br_stall(v_de_br_stall), .v_agex_br_stall(v_agex_br_stall),
        .v_mem_br_stall(v_mem_br_stall), .mem_pcmux(mem_pcmux), .target_pc(target_pc),
        .trap_pc(trap_pc), .de_npc(de_npc4), .de_ir(de_ir4), .de_v(de_v4),
        .fetch_count(fetch_count4), .bubble_count(bubble_count4));

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] npc;
        logic        v;
        logic [15:0] fc;
        logic [15:0] bc;
        logic [3:0]  fc4;
        logic [3:0]  bc4;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state: the architectural view of the fetch stage.
    int unsigned m_pc, m_ir, m_npc, m_v, m_fc, m_bc, m_fc4, m_bc4;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // Apply one cycle of inputs and predict the state after the next rising edge.
    task automatic cyc(input logic rst, input logic icr, input logic [15:0] data,
                       input logic dep, input logic mst, input logic vde, input logic vag,
                       input logic vme, input logic [1:0] pcmux, input logic [15:0] tgt,
                       input logic [15:0] trp);
        bit accept, can_fetch;
        exp_t e;
        @(negedge clk);
        reset = rst; icache_r = icr; icache_data = data; dep_stall = dep;
        mem_stall = mst; v_de_br_stall = vde; v_agex_br_stall = vag;
        v_mem_br_stall = vme; mem_pcmux = pcmux; target_pc = tgt; trap_pc = trp;
        if (rst) begin
            m_pc = 32'h3000; m_ir = 0; m_npc = 0; m_v = 0;
            m_fc = 0; m_bc = 0; m_fc4 = 0; m_bc4 = 0;
        end else begin
            accept    = !dep && !mst;
            can_fetch = icr && !(vde || vag || vme);
            if (accept) begin
                m_v   = can_fetch;
                m_ir  = data;
                m_npc = (m_pc + 2) % 65536;
                if (can_fetch) begin
                    if (m_fc < 65535) m_fc++;
                    if (m_fc4 < 15) m_fc4++;
                end else begin
                    if (m_bc < 65535) m_bc++;
                    if (m_bc4 < 15) m_bc4++;
                end
            end
            if (vme && !mst) begin
                if (pcmux == 2'd1) m_pc = tgt;
                else if (pcmux == 2'd2) m_pc = trp;
            end else if (accept && can_fetch) begin
                m_pc = (m_pc + 2) % 65536;
            end
        end
        e.pc = m_pc[15:0]; e.ir = m_ir[15:0]; e.npc = m_npc[15:0]; e.v = m_v[0];
        e.fc = m_fc[15:0]; e.bc = m_bc[15:0]; e.fc4 = m_fc4[3:0]; e.bc4 = m_bc4[3:0];
        exp_q.push_back(e);
    endtask

    task automatic run(input logic icr, input logic [15:0] data, input logic dep,
                       input logic mst, input logic vde, input logic vag, input logic vme,
                       input logic [1:0] pcmux, input logic [15:0] tgt);
        cyc(1'b0, icr, data, dep, mst, vde, vag, vme, pcmux, tgt, 16'h0200);
    endtask

    // Monitor: compare DUT outputs with the oldest prediction after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pc",           icache_addr,            e.pc);
                check("de_ir",        de_ir,                  e.ir);
                check("de_npc",       de_npc,                 e.npc);
                check("de_v",         {15'h0000, de_v},       {15'h0000, e.v});
                check("fetch_count",  fetch_count,            e.fc);
                check("bubble_count", bubble_count,           e.bc);
                check("pc_w4",        icache_addr4,           e.pc);
                check("de_v_w4",      {15'h0000, de_v4},      {15'h0000, e.v});
                check("fetch_cnt_w4", {12'h000, fetch_count4},  {12'h000, e.fc4});
                check("bubble_cnt_w4",{12'h000, bubble_count4}, {12'h000, e.bc4});
            end
        end
    end

    initial begin
        reset = 1'b1; icache_r = 1'b0; icache_data = 16'h0000; dep_stall = 1'b0;
        mem_stall = 1'b0; v_de_br_stall = 1'b0; v_agex_br_stall = 1'b0;
        v_mem_br_stall = 1'b0; mem_pcmux = 2'd0; target_pc = 16'h0000; trap_pc = 16'h0000;

        // reset then sequential fetch of A, B, C
        cyc(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000);
        cyc(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000);
        run(1'b1, 16'hA00A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        run(1'b1, 16'hB00B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        run(1'b1, 16'hC00C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        // I-cache miss for 3 cycles, then hit
        for (int i = 0; i < 3; i++) run(1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        run(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        // dependency stall with icache ready: everything holds
        for (int i = 0; i < 2; i++) run(1'b1, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        run(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        // taken branch: fetch it, then DE/AGEX/MEM windows, redirect to 4000
        run(1'b1, 16'h0E01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        run(1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
        run(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000);
        run(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 16'h4000);
        run(1'b1, 16'h4444, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        // trap redirect held off by mem_stall, then taken
        for (int i = 0; i < 2; i++) run(1'b1, 16'h6666, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 16'h0000);
        run(1'b1, 16'h6666, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'h0000);
        // fall-through resolutions (mux 0 and reserved 3) keep the PC
        run(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'h9000);
        run(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 16'h9000);
        // wrap at FFFE
        run(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 16'hFFFE);
        run(1'b1, 16'h8888, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        // saturate the narrow counters
        for (int i = 0; i < 20; i++) run(1'b1, 16'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        // reset mid-stall
        run(1'b1, 16'h9999, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 16'h1234);
        cyc(1'b1, 1'b1, 16'h9999, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 16'h1234, 16'h0200);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 249) == 0), ($urandom_range(0, 7) != 0), 16'($urandom),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 7) == 0), 2'($urandom),
                (($urandom_range(0, 3) == 0) ? 16'hFFFE : (16'($urandom) & 16'hFFFE)),
                16'($urandom) & 16'hFFFE);
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
